spi_slave_rx_tx: RTL and testbench

SPI slave endpoint that receives bytes from the SPI master on `mosi` and returns a preloaded byte on `miso` within the same frame. It sits directly downstream of the SPI master stage, on the same `sclk` domain, and consumes the master's `ss`/`mosi` and drives its `miso`. Received bytes are queued in a small receive FIFO with a valid/ready handshake toward the local consumer.

---
 rtl/spi_slave_rx_tx.sv | 209 ++++++++++++++++++++
 tb/tb_spi_slave_rx_tx.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx_tx.sv
// -----------------------------------------------------------------------------
// spi_slave_rx_tx
// SPI slave endpoint on the sclk domain. Shifts a byte in from mosi (LSB first)
// while returning the preloaded transmit byte on miso (LSB first) in the same
// frame. Completed bytes enter a small receive FIFO drained by a valid/ready
// consumer.
//
// Ports
//   sclk_i        sole clock, rising edge
//   rst_i         synchronous active-high reset
//   ss_i          slave select, active low
//   mosi_i        serial data in, LSB first
//   miso_o        serial data out, LSB first (combinational)
//   tx_data_i     byte to return in the next frame
//   tx_load_i     load tx_data_i into the transmit buffer while tx_ready_o
//   tx_ready_o    high while idle
//   rx_data_o     FIFO head byte
//   rx_valid_o    FIFO not empty
//   rx_ready_i    consumer pops head when rx_valid_o && rx_ready_i
//   rx_overrun_o  one-cycle pulse: completed byte dropped because FIFO full
//   frame_err_o   one-cycle pulse: ss rose before 8 bits were received
// -----------------------------------------------------------------------------
module spi_slave_rx_tx #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       sclk_i,
    input  logic       rst_i,
    input  logic       ss_i,
    input  logic       mosi_i,
    output logic       miso_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_load_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       rx_overrun_o,
    output logic       frame_err_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_WAIT_HI = 2'd2
    } state_e;

    state_e      state_q;
    state_e      state_d;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  rx_shift_q;
    logic [7:0]  tx_buf_q;
    logic        post_rst_q;   // high only on the first edge after reset
    logic        overrun_q;
    logic        frame_err_q;
    logic [7:0]  fifo_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;

    logic        fifo_empty_s;
    logic        fifo_full_s;
    logic        push_s;
    logic        pop_s;
    logic        wr_en_s;
    logic [7:0]  push_byte_s;

    // FIFO status and handshake decode
    assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
    assign fifo_full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                          (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_s       = (state_q == ST_SHIFT) && !ss_i && (bit_cnt_q == 3'd7);
    assign pop_s        = !fifo_empty_s && rx_ready_i;
    // A pop on the same edge frees the slot a full FIFO needs for the push
    assign wr_en_s      = push_s && (!fifo_full_s || pop_s);

    // Completed byte: bits 0..6 already shifted, bit 7 is on mosi right now
    always_comb begin
        push_byte_s    = rx_shift_q;
        push_byte_s[7] = mosi_i;
    end

    assign rx_valid_o   = !fifo_empty_s;
    assign rx_data_o    = fifo_q[rd_ptr_q[AW-1:0]];
    assign rx_overrun_o = overrun_q;
    assign frame_err_o  = frame_err_q;

    // FSM state register
    always_ff @(posedge sclk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                // A frame already in progress when reset released is skipped
                if (!ss_i) begin
                    state_d = post_rst_q ? ST_WAIT_HI : ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (ss_i) begin
                    state_d = ST_IDLE;
                end else if (bit_cnt_q == 3'd7) begin
                    state_d = ST_WAIT_HI;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_WAIT_HI: begin
                if (ss_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_HI;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: tx_ready and the miso bit presented for the next sample
    always_comb begin
        tx_ready_o = (state_q == ST_IDLE);
        miso_o     = tx_buf_q[0];
        if (ss_i) begin
            miso_o = tx_buf_q[0];
        end else begin
            case (state_q)
                ST_IDLE:    miso_o = tx_buf_q[1];
                ST_SHIFT:   miso_o = tx_buf_q[bit_cnt_q];
                ST_WAIT_HI: miso_o = tx_buf_q[7];
                default:    miso_o = tx_buf_q[0];
            endcase
        end
    end

    // Shift register, bit counter, transmit buffer and status pulses
    always_ff @(posedge sclk_i) begin
        if (rst_i) begin
            bit_cnt_q   <= 3'd0;
            rx_shift_q  <= 8'd0;
            tx_buf_q    <= 8'd0;
            post_rst_q  <= 1'b1;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            post_rst_q  <= 1'b0;
            overrun_q   <= push_s && fifo_full_s && !pop_s;
            frame_err_q <= (state_q == ST_SHIFT) && ss_i;
            if (tx_load_i && (state_q == ST_IDLE)) begin
                tx_buf_q <= tx_data_i;
            end
            case (state_q)
                ST_IDLE: begin
                    if (!ss_i && !post_rst_q) begin
                        rx_shift_q <= {7'd0, mosi_i};
                        bit_cnt_q  <= 3'd1;
                    end
                end
                ST_SHIFT: begin
                    if (ss_i) begin
                        rx_shift_q <= 8'd0;
                        bit_cnt_q  <= 3'd0;
                    end else begin
                        rx_shift_q[bit_cnt_q] <= mosi_i;
                        // wraps to 0 after bit 7, ready for the next frame
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                end
                ST_WAIT_HI: begin
                    bit_cnt_q <= 3'd0;
                end
                default: begin
                    bit_cnt_q  <= 3'd0;
                    rx_shift_q <= 8'd0;
                end
            endcase
        end
    end

    // Receive FIFO storage and pointers
    always_ff @(posedge sclk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= 8'd0;
            end
        end else begin
            if (wr_en_s) begin
                fifo_q[wr_ptr_q[AW-1:0]] <= push_byte_s;
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Testbench for spi_slave_rx_tx: table-driven frames, directed corner cases and
// randomized traffic checked against a frame-level reference model.
module tb_spi_slave_rx_tx;

    localparam int DEPTH = 4;

    logic       sclk = 1'b0;
    logic       rst = 1'b0;
    logic       ss = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [7:0] tx_data = 8'd0;
    logic       tx_load = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       rx_overrun;
    logic       frame_err;

    spi_slave_rx_tx #(.FIFO_DEPTH(DEPTH)) dut (
        .sclk_i(sclk), .rst_i(rst), .ss_i(ss), .mosi_i(mosi), .miso_o(miso),
        .tx_data_i(tx_data), .tx_load_i(tx_load), .tx_ready_o(tx_ready),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
        .rx_overrun_o(rx_overrun), .frame_err_o(frame_err)
    );

    always #5 sclk = ~sclk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [7:0] q[$];
    logic [7:0] tx_m = 8'd0;
    int         low_cnt = 0;
    bit         first_rst = 1'b0;
    bit         spoiled = 1'b0;
    bit         in_frame = 1'b0;
    bit         exp_ovr = 1'b0;
    bit         exp_ferr = 1'b0;
    logic [7:0] bits = 8'd0;

    // master-side capture
    int         mpos = 0;
    logic       last_idle_miso = 1'b0;
    logic [7:0] mbits = 8'd0;
    logic [7:0] m_exp = 8'd0;
    logic [7:0] last_master = 8'd0;
    bit         mframe_ok = 1'b0;
    int         ovr_seen = 0;
    int         ferr_seen = 0;
    bit         rand_rdy = 1'b0;
    logic [7:0] drained[$];

    typedef struct {
        logic [7:0] tx;
        logic [7:0] mosi_byte;
        logic [7:0] exp_rx;
        logic [7:0] exp_master;
    } vec_t;
    vec_t vec[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level reference: counts low cycles, pushes on the 8th bit
    task automatic model_edge();
        bit pop;
        bit push;
        exp_ovr  = 1'b0;
        exp_ferr = 1'b0;
        if (rst) begin
            q.delete();
            tx_m      = 8'd0;
            low_cnt   = 0;
            first_rst = 1'b1;
            spoiled   = 1'b0;
            in_frame  = 1'b0;
            mframe_ok = 1'b0;
        end else begin
            pop  = rx_ready && (q.size() != 0);
            push = 1'b0;
            if (first_rst && !ss) spoiled = 1'b1;
            first_rst = 1'b0;
            if (ss) begin
                if (!spoiled && low_cnt >= 1 && low_cnt <= 7) exp_ferr = 1'b1;
                low_cnt = 0;
                spoiled = 1'b0;
            end else if (!spoiled && low_cnt < 8) begin
                bits[low_cnt] = mosi;
                low_cnt++;
                if (low_cnt == 8) push = 1'b1;
            end
            if (tx_load && !in_frame) tx_m = tx_data;
            in_frame = !ss;
            if (pop) void'(q.pop_front());
            if (push) begin
                if (q.size() < DEPTH) q.push_back(bits);
                else exp_ovr = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        chk("rx_valid", 32'(rx_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("rx_data", 32'(rx_data), 32'(q[0]));
        chk("rx_overrun", 32'(rx_overrun), 32'(exp_ovr));
        chk("frame_err", 32'(frame_err), 32'(exp_ferr));
        chk("tx_ready", 32'(tx_ready), 32'(!in_frame));
        if (rx_overrun) ovr_seen++;
        if (frame_err) ferr_seen++;
    endtask

    // One sclk cycle: drive, sample miso mid-cycle, model the edge, check
    task automatic cyc(input logic s, input logic m);
        logic mm;
        ss   = s;
        mosi = m;
        if (rand_rdy) rx_ready = 1'($urandom % 2);
        #4;
        mm = miso;
        if (s) begin
            last_idle_miso = mm;
            mpos = 0;
        end else begin
            if (mpos == 0) begin
                mbits[0]  = last_idle_miso;
                m_exp     = tx_m;
                mframe_ok = !rst && !spoiled && !first_rst;
            end else if (mpos <= 7) begin
                mbits[mpos] = mm;
            end
            if (rst) mframe_ok = 1'b0;
            if (mpos == 7 && mframe_ok) begin
                chk("master_rx", 32'(mbits), 32'(m_exp));
                last_master = mbits;
            end
            mpos++;
        end
        @(posedge sclk);
        model_edge();
        #1;
        check_outputs();
        tx_load = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input int load_at,
                              input logic [7:0] ld, input int pop_at);
        for (int i = 0; i < nbits; i++) begin
            if (i == load_at) begin
                tx_load = 1'b1;
                tx_data = ld;
            end
            if (pop_at >= 0) rx_ready = (i == pop_at);
            cyc(1'b0, d[i % 8]);
        end
        if (pop_at >= 0) rx_ready = 1'b0;
        cyc(1'b1, 1'b0);
    endtask

    task automatic load_tx(input logic [7:0] v);
        tx_load = 1'b1;
        tx_data = v;
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
    endtask

    task automatic drain();
        drained.delete();
        rx_ready = 1'b1;
        for (int i = 0; i < 2 * DEPTH && rx_valid; i++) begin
            drained.push_back(rx_data);
            cyc(1'b1, 1'b0);
        end
        rx_ready = 1'b0;
    endtask

    initial begin
        int ovr0;
        int ferr0;
        int r;
        int nb;

        vec[0] = '{8'hA5, 8'h3C, 8'h3C, 8'hA5};
        vec[1] = '{8'h00, 8'hFF, 8'hFF, 8'h00};
        vec[2] = '{8'hFF, 8'h00, 8'h00, 8'hFF};
        vec[3] = '{8'h5A, 8'h81, 8'h81, 8'h5A};

        // reset state
        rst = 1'b1;
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_overrun", 32'(rx_overrun), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_miso", 32'(miso), 32'd0);
        rst = 1'b0;
        cyc(1'b1, 1'b0);

        // table-driven single frames
        for (int i = 0; i < 4; i++) begin
            load_tx(vec[i].tx);
            last_master = 8'hxx;
            send_frame(vec[i].mosi_byte, 8, -1, 8'd0, -1);
            chk("tbl_valid", 32'(rx_valid), 32'd1);
            chk("tbl_head", 32'(rx_data), 32'(vec[i].exp_rx));
            chk("tbl_master", 32'(last_master), 32'(vec[i].exp_master));
            drain();
            chk("tbl_drain_n", 32'(drained.size()), 32'd1);
        end

        // overrun on the fifth frame, then in-order drain
        ovr0 = ovr_seen;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 8, -1, 8'd0, -1);
        chk("ovr_pulses", 32'(ovr_seen - ovr0), 32'd1);
        drain();
        chk("ovr_drain_n", 32'(drained.size()), 32'd4);
        for (int i = 0; i < 4 && i < drained.size(); i++)
            chk("ovr_drain", 32'(drained[i]), 32'(i + 1));

        // full FIFO, push coincides with pop
        ovr0 = ovr_seen;
        send_frame(8'h11, 8, -1, 8'd0, -1);
        send_frame(8'h22, 8, -1, 8'd0, -1);
        send_frame(8'h33, 8, -1, 8'd0, -1);
        send_frame(8'h44, 8, -1, 8'd0, -1);
        send_frame(8'h77, 8, -1, 8'd0, 7);
        chk("fullpop_no_ovr", 32'(ovr_seen - ovr0), 32'd0);
        drain();
        chk("fullpop_n", 32'(drained.size()), 32'd4);
        if (drained.size() == 4) begin
            chk("fullpop_0", 32'(drained[0]), 32'h22);
            chk("fullpop_3", 32'(drained[3]), 32'h77);
        end

        // ss raised after 5 bits
        send_frame(8'h5C, 8, -1, 8'd0, -1);
        ferr0 = ferr_seen;
        send_frame(8'h15, 5, -1, 8'd0, -1);
        chk("ferr_pulses", 32'(ferr_seen - ferr0), 32'd1);
        chk("ferr_fifo_head", 32'(rx_data), 32'h5C);
        send_frame(8'h9E, 8, -1, 8'd0, -1);
        drain();
        chk("ferr_n", 32'(drained.size()), 32'd2);
        if (drained.size() == 2) chk("ferr_next", 32'(drained[1]), 32'h9E);

        // reset asserted at bit 3 with ss held low
        load_tx(8'h66);
        ferr0 = ferr_seen;
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        rst = 1'b1;
        cyc(1'b0, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b0);
        chk("rstmid_no_ferr", 32'(ferr_seen - ferr0), 32'd0);
        chk("rstmid_empty", 32'(rx_valid), 32'd0);
        last_master = 8'hxx;
        send_frame(8'h42, 8, -1, 8'd0, -1);
        chk("rstmid_head", 32'(rx_data), 32'h42);
        chk("rstmid_master", 32'(last_master), 32'h00);
        drain();

        // tx_load during SHIFT is ignored; byte resent next frame
        load_tx(8'h3C);
        send_frame(8'hC3, 8, 3, 8'hFF, -1);
        chk("ldshift_master", 32'(last_master), 32'h3C);
        send_frame(8'h0F, 8, -1, 8'd0, -1);
        chk("resend_master", 32'(last_master), 32'h3C);
        drain();

        // randomized traffic
        rand_rdy = 1'b1;
        for (int it = 0; it < 300; it++) begin
            r = int'($urandom % 20);
            if (r < 3) begin
                load_tx(8'($urandom));
            end else if (r == 3) begin
                send_frame(8'($urandom), int'($urandom_range(7, 1)), -1, 8'd0, -1);
            end else if (r == 4) begin
                nb = int'($urandom_range(6, 1));
                for (int i = 0; i < nb; i++) cyc(1'b0, 1'($urandom % 2));
                rst = 1'b1;
                cyc(1'b0, 1'($urandom % 2));
                rst = 1'b0;
                nb = int'($urandom_range(8, 1));
                for (int i = 0; i < nb; i++) cyc(1'b0, 1'($urandom % 2));
                cyc(1'b1, 1'b0);
            end else begin
                send_frame(8'($urandom), int'($urandom_range(10, 8)),
                           ($urandom % 4 == 0) ? int'($urandom_range(7, 1)) : -1,
                           8'($urandom), -1);
            end
            if ($urandom % 3 == 0) cyc(1'b1, 1'b0);
        end
        rand_rdy = 1'b0;
        rx_ready = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
